bp_io_cmd_arbiter: RTL and testbench
====================================

# bp_io_cmd_arbiter

Shares a single BedRock I/O command/response channel between several requesters, such as the stream NBF loader and a host debug port, in front of the I/O network. It arbitrates commands round-robin with a grant lock, limits outstanding commands to the network credit budget, and records the requester ID of every issued command. Each in-order response is routed back to the requester that issued the matching command.

## Interface
- `num_req_p`, default 2: number of requesters; must be at least 2.
- `mem_header_width_p`, default 0 (must be set): BedRock memory header width.
- `data_width_p`, default 512: command/response data width.
- `max_credits_p`, default 16: maximum outstanding commands; equals the tag FIFO depth.
- `clk_i`  in  1  clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `req_header_i`  in  `num_req_p*mem_header_width_p`  per-requester command headers.
- `req_data_i`  in  `num_req_p*data_width_p`  per-requester command data.
- `req_v_i`  in  `num_req_p`  per-requester command valid.
- `req_yumi_o`  out  `num_req_p`  command consumed, one-hot or zero.
- `io_cmd_header_o`  out  `mem_header_width_p`  muxed command header.
- `io_cmd_data_o`  out  `data_width_p`  muxed command data.
- `io_cmd_v_o`  out  1  command valid.
- `io_cmd_yumi_i`  in  1  downstream consumes the command.
- `io_resp_header_i`  in  `mem_header_width_p`  response header.
- `io_resp_data_i`  in  `data_width_p`  response data.
- `io_resp_v_i`  in  1  response valid.
- `io_resp_ready_o`  out  1  response accepted.
- `resp_header_o`  out  `mem_header_width_p`  broadcast response header.
- `resp_data_o`  out  `data_width_p`  broadcast response data.
- `resp_v_o`  out  `num_req_p`  one-hot response valid.
- `resp_ready_i`  in  `num_req_p`  per-requester response ready.
- `idle_o`  out  1  no outstanding commands and no command presented.
- `error_o`  out  1  sticky: a response arrived with no outstanding command.

## Operation
- Arbiter states:
  - IDLE: grant unlocked. The round-robin pointer `rr_r` selects the first valid requester at or after `rr_r`.
  - LOCKED: `io_cmd_v_o` was asserted without `io_cmd_yumi_i`. The grant register `gnt_r` holds the selection until yumi, so the downstream sees a stable valid command.
- Requesters must hold `req_v_i` and their payload until yumi; the arbiter never withdraws a presented command.
- Command valid: `io_cmd_v_o = (locked ? 1 : |req_v_i) & ~tag_full`.
  - `tag_full` means the outstanding count equals `max_credits_p`.
  - No command is issued when the count is full, even if a response pops in the same cycle.
- On `io_cmd_yumi_i`:
  - `req_yumi_o[gnt] = 1`.
  - Push `gnt` into the tag FIFO.
  - `rr_r <= gnt+1`, wrapping modulo `num_req_p`.
  - Unlock the grant.
- Response routing: the head of the tag FIFO (`head_id`) selects the destination.
  - `resp_v_o[head_id] = io_resp_v_i & ~tag_empty`.
  - `io_resp_ready_o = resp_ready_i[head_id] & ~tag_empty`.
  - Pop on `io_resp_v_i & io_resp_ready_o`.
- Orphan response (`io_resp_v_i` while the FIFO is empty):
  - `io_resp_ready_o = 1`, so the response is drained and dropped.
  - `error_o` sets and stays set until reset.
- `idle_o = tag_empty & ~io_cmd_v_o & ~locked`.
- Header and data pass through unmodified. No header fields are rewritten.

## Timing
- Command path is zero latency: `req_*` to `io_cmd_*` is combinational through the grant mux, and `io_cmd_yumi_i` to `req_yumi_o` is combinational.
- Response path is zero latency and combinational in both directions.
- Push and pop in the same cycle are allowed and leave the count unchanged. The full check uses the registered count, so no bypass.
- A requester may be granted on consecutive cycles only if it is the sole valid requester.
- Reset:
  - `rr_r = 0`, unlocked, tag FIFO empty.
  - `error_o = 0`, `idle_o = 1`, all `v`/`yumi`/`ready` outputs 0.
  - Reset mid-operation discards all outstanding tags. Responses to those commands then count as orphans and set `error_o`.

## Structure
- Shared package `bp_me_pkg`:
  - requester-ID width `` `BSG_SAFE_CLOG2(num_req_p) ``.
  - enum for the requester slots: `e_io_req_nbf = 0`, `e_io_req_host = 1`.
- Sub-module `bsg_fifo_1r1w_small`: width is the ID width, depth is `max_credits_p`. Its full and empty flags provide `tag_full` and `tag_empty`.
- Arbitration is inline: a one-hot rotate and priority-encode from `rr_r`, plus the lock register.

## Test plan
- Single requester 0 sends 3 commands, downstream yumis each cycle → 3 `req_yumi_o[0]` pulses, tags 0,0,0 queued; 3 responses each assert only `resp_v_o[0]`.
- Both requesters valid continuously with `rr_r = 0` → grant order 0,1,0,1. Responses return in the order 0,1,0,1 to the matching `resp_v_o` bit.
- Hold `io_cmd_yumi_i = 0` for 5 cycles while requester 1 becomes valid mid-stall → grant stays on requester 0 and the header stays stable until yumi.
- `max_credits_p = 4`, 4 commands issued with no responses → `io_cmd_v_o = 0`. One response pops, then the next cycle `io_cmd_v_o = 1`.
- Response with an empty FIFO → `io_resp_ready_o = 1`, `resp_v_o = 0`, `error_o` rises and stays high until `reset_i`.
- Assert `reset_i` with 2 outstanding commands → the next cycle `idle_o = 1`, `error_o = 0`, FIFO empty, `rr_r = 0`.

Source files
------------

// File: rtl/bp_me_pkg.sv
// Shared BedRock ME types for the I/O command arbiter.
// Requester slots, arbiter states and ID width helper.
package bp_me_pkg;

  typedef enum logic [0:0] {
    e_io_req_nbf  = 1'b0,
    e_io_req_host = 1'b1
  } bp_io_req_e;

  typedef enum logic {
    e_arb_idle   = 1'b0,
    e_arb_locked = 1'b1
  } bp_io_arb_state_e;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small circular FIFO holding requester IDs of issued commands.
// Count-based full/empty so any depth works.
module bsg_fifo_1r1w_small
  import bp_me_pkg::*;
#(
  parameter int width_p = 1,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i,
  output logic               full_o,
  output logic               empty_o
);

  localparam int ptr_w_lp = safe_clog2(els_p);
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp-1:0] wr_ptr_r;
  logic [ptr_w_lp-1:0] rd_ptr_r;
  logic [cnt_w_lp-1:0] cnt_r;
  logic                enq;
  logic                deq;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(
    input logic [ptr_w_lp-1:0] p
  );
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_r == cnt_w_lp'(els_p));
  assign empty_o = (cnt_r == '0);
  assign ready_o = ~full_o;
  assign v_o     = ~empty_o;
  assign data_o  = mem_r[rd_ptr_r];
  assign enq     = v_i & ~full_o;
  assign deq     = yumi_i & ~empty_o;

  // Storage write; contents need no reset
  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wr_ptr_r] <= data_i;
  end

  // Pointers and occupancy count
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (enq) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (deq) rd_ptr_r <= ptr_inc(rd_ptr_r);
      unique case ({enq, deq})
        2'b10:   cnt_r <= cnt_r + 1'b1;
        2'b01:   cnt_r <= cnt_r - 1'b1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/bp_io_cmd_arbiter.sv
// Round-robin I/O command arbiter with grant lock and credit limit.
// Responses return in order to the requester whose ID heads the tag FIFO.
module bp_io_cmd_arbiter
  import bp_me_pkg::*;
#(
  parameter int num_req_p          = 2,
  parameter int mem_header_width_p = 0,
  parameter int data_width_p       = 512,
  parameter int max_credits_p      = 16
) (
  input  logic                                    clk_i,
  input  logic                                    reset_i,
  input  logic [num_req_p*mem_header_width_p-1:0] req_header_i,
  input  logic [num_req_p*data_width_p-1:0]       req_data_i,
  input  logic [num_req_p-1:0]                    req_v_i,
  output logic [num_req_p-1:0]                    req_yumi_o,
  output logic [mem_header_width_p-1:0]           io_cmd_header_o,
  output logic [data_width_p-1:0]                 io_cmd_data_o,
  output logic                                    io_cmd_v_o,
  input  logic                                    io_cmd_yumi_i,
  input  logic [mem_header_width_p-1:0]           io_resp_header_i,
  input  logic [data_width_p-1:0]                 io_resp_data_i,
  input  logic                                    io_resp_v_i,
  output logic                                    io_resp_ready_o,
  output logic [mem_header_width_p-1:0]           resp_header_o,
  output logic [data_width_p-1:0]                 resp_data_o,
  output logic [num_req_p-1:0]                    resp_v_o,
  input  logic [num_req_p-1:0]                    resp_ready_i,
  output logic                                    idle_o,
  output logic                                    error_o
);

  localparam int id_w_lp = safe_clog2(num_req_p);

  bp_io_arb_state_e state_r;
  bp_io_arb_state_e state_n;

  logic [id_w_lp-1:0] rr_r;
  logic [id_w_lp-1:0] gnt_r;
  logic [id_w_lp-1:0] pick;
  logic [id_w_lp-1:0] gnt;
  logic [id_w_lp-1:0] head_id;
  logic               locked;
  logic               cmd_fire;
  logic               tag_full;
  logic               tag_empty;
  logic               tag_ready;
  logic               tag_v;
  logic               resp_pop;
  logic               error_r;

  logic [num_req_p*mem_header_width_p-1:0] hdr_sh;
  logic [num_req_p*data_width_p-1:0]       data_sh;

  assign locked = (state_r == e_arb_locked);
  assign gnt    = locked ? gnt_r : pick;

  // First valid requester at or after the round-robin pointer
  always_comb begin : pick_blk
    int  idx;
    logic found;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < num_req_p; i++) begin
      idx = int'(rr_r) + i;
      if (idx >= num_req_p) idx = idx - num_req_p;
      if (!found && req_v_i[idx]) begin
        found = 1'b1;
        pick  = id_w_lp'(idx);
      end
    end
  end

  assign io_cmd_v_o = (locked | (|req_v_i)) & ~tag_full & ~reset_i;
  assign cmd_fire   = io_cmd_v_o & io_cmd_yumi_i;

  assign hdr_sh  = req_header_i >> (int'(gnt) * mem_header_width_p);
  assign data_sh = req_data_i >> (int'(gnt) * data_width_p);
  assign io_cmd_header_o = hdr_sh[mem_header_width_p-1:0];
  assign io_cmd_data_o   = data_sh[data_width_p-1:0];

  // Consume pulse goes only to the granted requester
  always_comb begin
    req_yumi_o = '0;
    if (cmd_fire) req_yumi_o[gnt] = 1'b1;
  end

  // Lock holds the grant while a presented command waits for yumi
  always_comb begin
    state_n = state_r;
    unique case (state_r)
      e_arb_idle:   if (io_cmd_v_o & ~io_cmd_yumi_i) state_n = e_arb_locked;
      e_arb_locked: if (cmd_fire) state_n = e_arb_idle;
      default:      state_n = e_arb_idle;
    endcase
  end

  // Arbiter state, grant and round-robin pointer
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_arb_idle;
      gnt_r   <= '0;
      rr_r    <= '0;
    end else begin
      state_r <= state_n;
      if (!locked) gnt_r <= pick;
      if (cmd_fire) begin
        rr_r <= (gnt == id_w_lp'(num_req_p - 1)) ? '0 : gnt + 1'b1;
      end
    end
  end

  bsg_fifo_1r1w_small #(
    .width_p (id_w_lp),
    .els_p   (max_credits_p)
  ) tag_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (cmd_fire),
    .ready_o (tag_ready),
    .data_i  (gnt),
    .v_o     (tag_v),
    .data_o  (head_id),
    .yumi_i  (resp_pop),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  assign resp_header_o = io_resp_header_i;
  assign resp_data_o   = io_resp_data_i;

  // Orphan responses are drained; tracked ones wait for their owner
  assign io_resp_ready_o = ~reset_i &
    (tag_empty ? io_resp_v_i : resp_ready_i[head_id]);
  assign resp_pop = io_resp_v_i & io_resp_ready_o & tag_v;

  // Route the response valid to the head-of-queue requester
  always_comb begin
    resp_v_o = '0;
    if (io_resp_v_i & ~tag_empty & ~reset_i) resp_v_o[head_id] = 1'b1;
  end

  // Sticky orphan-response flag
  always_ff @(posedge clk_i) begin
    if (reset_i) error_r <= 1'b0;
    else if (io_resp_v_i & tag_empty) error_r <= 1'b1;
  end

  assign error_o = error_r;
  assign idle_o  = tag_empty & ~io_cmd_v_o & ~locked;

  logic unused_tag_ready;
  assign unused_tag_ready = tag_ready;

endmodule

// File: tb/tb_bp_io_cmd_arbiter.sv
// Scoreboard bench for bp_io_cmd_arbiter.
// Issued grants are queued and matched against routed responses.
module tb_bp_io_cmd_arbiter;

  localparam int NR = 2;
  localparam int HW = 16;
  localparam int DW = 32;
  localparam int CR = 4;

  logic              clk_i = 1'b0;
  logic              reset_i = 1'b1;
  logic [NR*HW-1:0]  req_header_i = '0;
  logic [NR*DW-1:0]  req_data_i = '0;
  logic [NR-1:0]     req_v_i = '0;
  logic [NR-1:0]     req_yumi_o;
  logic [HW-1:0]     io_cmd_header_o;
  logic [DW-1:0]     io_cmd_data_o;
  logic              io_cmd_v_o;
  logic              io_cmd_yumi_i = 1'b0;
  logic [HW-1:0]     io_resp_header_i = '0;
  logic [DW-1:0]     io_resp_data_i = '0;
  logic              io_resp_v_i = 1'b0;
  logic              io_resp_ready_o;
  logic [HW-1:0]     resp_header_o;
  logic [DW-1:0]     resp_data_o;
  logic [NR-1:0]     resp_v_o;
  logic [NR-1:0]     resp_ready_i = '0;
  logic              idle_o;
  logic              error_o;

  bp_io_cmd_arbiter #(
    .num_req_p          (NR),
    .mem_header_width_p (HW),
    .data_width_p       (DW),
    .max_credits_p      (CR)
  ) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .req_header_i     (req_header_i),
    .req_data_i       (req_data_i),
    .req_v_i          (req_v_i),
    .req_yumi_o       (req_yumi_o),
    .io_cmd_header_o  (io_cmd_header_o),
    .io_cmd_data_o    (io_cmd_data_o),
    .io_cmd_v_o       (io_cmd_v_o),
    .io_cmd_yumi_i    (io_cmd_yumi_i),
    .io_resp_header_i (io_resp_header_i),
    .io_resp_data_i   (io_resp_data_i),
    .io_resp_v_i      (io_resp_v_i),
    .io_resp_ready_o  (io_resp_ready_o),
    .resp_header_o    (resp_header_o),
    .resp_data_o      (resp_data_o),
    .resp_v_o         (resp_v_o),
    .resp_ready_i     (resp_ready_i),
    .idle_o           (idle_o),
    .error_o          (error_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  int          sb_q[$];
  logic [15:0] hdr [NR];
  int          m_rr;
  int          m_gnt;
  logic        m_locked;
  logic        m_err;
  logic [1:0]  m_held;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int mpick(input int rr, input logic [1:0] v);
    int idx;
    for (int i = 0; i < NR; i++) begin
      idx = (rr + i) % NR;
      if (v[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic cycle(input logic [1:0] v, input logic y,
                       input logic rv, input logic [1:0] rdy);
    int          g;
    int          hid;
    logic        ev;
    logic        pop;
    logic [1:0]  ey;
    logic [15:0] rh;
    logic [31:0] rd;
    req_v_i       = v;
    io_cmd_yumi_i = y;
    io_resp_v_i   = rv;
    resp_ready_i  = rdy;
    rh = 16'($urandom);
    rd = $urandom;
    io_resp_header_i = rh;
    io_resp_data_i   = rd;
    req_header_i = {hdr[1], hdr[0]};
    req_data_i   = {hdr[1], ~hdr[1], hdr[0], ~hdr[0]};
    @(negedge clk_i);
    ev = (m_locked || v != 2'b00) && (sb_q.size() < CR);
    g  = m_locked ? m_gnt : mpick(m_rr, v);
    check("cmd_v", io_cmd_v_o, ev);
    if (ev) begin
      check("cmd_hdr", io_cmd_header_o, hdr[g]);
      check("cmd_data", io_cmd_data_o, {hdr[g], ~hdr[g]});
    end
    ey = (ev && y) ? (2'b01 << g) : 2'b00;
    check("req_yumi", req_yumi_o, ey);
    check("idle", idle_o, sb_q.size() == 0 && !ev && !m_locked);
    check("error", error_o, m_err);
    check("resp_hdr", resp_header_o, rh);
    check("resp_data", resp_data_o, rd);
    pop = 1'b0;
    if (sb_q.size() == 0) begin
      check("resp_v", resp_v_o, 2'b00);
      check("resp_rdy", io_resp_ready_o, rv);
      if (rv) m_err = 1'b1;
    end else begin
      hid = sb_q[0];
      check("resp_v", resp_v_o, rv ? (2'b01 << hid) : 2'b00);
      check("resp_rdy", io_resp_ready_o, rdy[hid]);
      pop = rv && rdy[hid];
    end
    if (pop) void'(sb_q.pop_front());
    if (ev && y) begin
      sb_q.push_back(g);
      hdr[g]   = hdr[g] + 16'h0011;
      m_rr     = (g + 1) % NR;
      m_locked = 1'b0;
    end else if (ev) begin
      m_locked = 1'b1;
      m_gnt    = g;
    end
    m_held = v & ~ey;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i       = 1'b1;
    req_v_i       = '0;
    io_cmd_yumi_i = 1'b0;
    io_resp_v_i   = 1'b0;
    resp_ready_i  = '0;
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    check("rst_idle", idle_o, 1'b1);
    check("rst_error", error_o, 1'b0);
    check("rst_cmd_v", io_cmd_v_o, 1'b0);
    check("rst_yumi", req_yumi_o, 2'b00);
    check("rst_resp_v", resp_v_o, 2'b00);
    check("rst_resp_rdy", io_resp_ready_o, 1'b0);
    sb_q.delete();
    m_rr = 0; m_gnt = 0; m_locked = 1'b0; m_err = 1'b0; m_held = '0;
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
  endtask

  initial begin
    hdr[0] = 16'hA000;
    hdr[1] = 16'hB000;
    do_reset();

    // single requester, three back-to-back commands and responses
    repeat (3) cycle(2'b01, 1'b1, 1'b0, 2'b00);
    repeat (3) cycle(2'b00, 1'b0, 1'b1, 2'b11);

    // both requesters valid, alternating grants; one backpressured resp
    do_reset();
    repeat (4) cycle(2'b11, 1'b1, 1'b0, 2'b00);
    cycle(2'b00, 1'b0, 1'b1, 2'b00);
    repeat (4) cycle(2'b00, 1'b0, 1'b1, 2'b11);

    // stall with requester 1 arriving mid-stall; grant stays locked
    repeat (2) cycle(2'b01, 1'b0, 1'b0, 2'b00);
    repeat (3) cycle(2'b11, 1'b0, 1'b0, 2'b00);
    cycle(2'b11, 1'b1, 1'b0, 2'b00);
    cycle(2'b10, 1'b1, 1'b0, 2'b00);
    repeat (2) cycle(2'b00, 1'b0, 1'b1, 2'b11);

    // credit exhaustion, then recovery the cycle after a pop
    repeat (4) cycle(2'b01, 1'b1, 1'b0, 2'b00);
    cycle(2'b01, 1'b1, 1'b0, 2'b00);
    cycle(2'b01, 1'b1, 1'b1, 2'b11);
    cycle(2'b01, 1'b1, 1'b0, 2'b00);
    repeat (4) cycle(2'b00, 1'b0, 1'b1, 2'b11);

    // orphan response sets the sticky error
    cycle(2'b00, 1'b0, 1'b1, 2'b00);
    repeat (3) cycle(2'b00, 1'b0, 1'b0, 2'b00);

    // reset with outstanding commands; their responses become orphans
    do_reset();
    repeat (2) cycle(2'b11, 1'b1, 1'b0, 2'b00);
    do_reset();
    cycle(2'b00, 1'b0, 1'b0, 2'b00);
    cycle(2'b00, 1'b0, 1'b1, 2'b11);
    cycle(2'b11, 1'b1, 1'b0, 2'b00);
    cycle(2'b00, 1'b0, 1'b1, 2'b11);

    // random traffic with held requests
    do_reset();
    for (int i = 0; i < 200; i++) begin
      logic [1:0] v;
      v = m_held | 2'($urandom);
      cycle(v, ($urandom % 4) != 0,
            (sb_q.size() > 0) && ($urandom % 2 == 1),
            2'($urandom));
    end
    while (sb_q.size() > 0) cycle(2'b00, 1'b0, 1'b1, 2'b11);
    cycle(2'b00, 1'b0, 1'b0, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
